adc_sar_control: RTL and testbench

Successive-approximation sequencer for the 12-bit capacitive SAR ADC. It runs the sample phase, then performs a binary search over the 12-bit DAC code, one bit per settle window, using the comparator decision. Its `dac_code_o` drives `data_in` of `adc_row_col_decoder`, which maps the code onto the 16×32 unit-capacitor matrix plus three binary caps. It sits between the digital host interface and the analog core.

---
 rtl/adc_pkg.sv | 21 ++
 rtl/adc_sar_control.sv | 108 ++++++++++
 tb/tb_adc_sar_control.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the SAR ADC digital control.
package adc_pkg;
    localparam int ADC_BITS = 12;
    localparam int CNT_BITS = 8;
    localparam int IDX_BITS = 4;

    localparam logic COMP_KEEP = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONV,
        DONE
    } sar_state_t;

    function automatic logic [ADC_BITS-1:0] bit_mask(
        input logic [IDX_BITS-1:0] idx
    );
        bit_mask = ADC_BITS'(1) << idx;
    endfunction
endpackage

// File: rtl/adc_sar_control.sv
// SAR sequencer: sample phase, then a 12-step binary search on the DAC code.
module adc_sar_control
    import adc_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic                comparator_i,
    output logic                sample_o,
    output logic                comp_strobe_o,
    output logic [ADC_BITS-1:0] dac_code_o,
    output logic [ADC_BITS-1:0] result_o,
    output logic                valid_o,
    output logic                busy_o
);

    localparam logic [CNT_BITS-1:0] SAMPLE_LOAD = CNT_BITS'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] SETTLE_LOAD = CNT_BITS'(SETTLE_CYCLES - 1);
    localparam logic [IDX_BITS-1:0] MSB_IDX     = IDX_BITS'(ADC_BITS - 1);

    sar_state_t          state;
    logic [CNT_BITS-1:0] cnt;
    logic [IDX_BITS-1:0] idx;
    logic [ADC_BITS-1:0] work;
    logic [ADC_BITS-1:0] work_upd;

    // Bit idx of work is still 0 here, so OR-ing in the decision is enough.
    assign work_upd = (comparator_i == COMP_KEEP) ? (work | bit_mask(idx))
                                                   : work;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            work          <= '0;
            sample_o      <= 1'b0;
            comp_strobe_o <= 1'b0;
            dac_code_o    <= '0;
            result_o      <= '0;
            valid_o       <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            valid_o       <= 1'b0;
            comp_strobe_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    dac_code_o <= '0;
                    if (start_i) begin
                        state    <= SAMPLE;
                        cnt      <= SAMPLE_LOAD;
                        sample_o <= 1'b1;
                        busy_o   <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt == '0) begin
                        state         <= CONV;
                        idx           <= MSB_IDX;
                        work          <= '0;
                        cnt           <= SETTLE_LOAD;
                        sample_o      <= 1'b0;
                        dac_code_o    <= bit_mask(MSB_IDX);
                        comp_strobe_o <= (SETTLE_LOAD == '0);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                CONV: begin
                    if (cnt != '0) begin
                        cnt           <= cnt - 8'd1;
                        comp_strobe_o <= (cnt == 8'd1);
                    end else begin
                        work <= work_upd;
                        if (idx != '0) begin
                            idx           <= idx - 4'd1;
                            cnt           <= SETTLE_LOAD;
                            dac_code_o    <= work_upd | bit_mask(idx - 4'd1);
                            comp_strobe_o <= (SETTLE_LOAD == '0);
                        end else begin
                            state      <= DONE;
                            result_o   <= work_upd;
                            valid_o    <= 1'b1;
                            dac_code_o <= work_upd;
                        end
                    end
                end
                DONE: begin
                    dac_code_o <= '0;
                    if (cont_i) begin
                        state    <= SAMPLE;
                        cnt      <= SAMPLE_LOAD;
                        sample_o <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sar_control.sv
// Directed bench for adc_sar_control: default and 1/1 timing instances.
module tb_adc_sar_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1, cont;
    logic [1:0]  mode;
    logic [11:0] vin;
    logic        comp0;
    logic        comp1;

    logic        sample0, strobe0, valid0, busy0;
    logic [11:0] dac0, result0;
    logic        sample1, strobe1, valid1, busy1;
    logic [11:0] dac1, result1;

    int checks = 0;
    int errors = 0;

    int          vcyc[$];
    logic [11:0] vres[$];
    logic [11:0] trials[$];
    logic        busy_at[0:127];
    logic        strobe_at[0:127];

    always #5 clk = ~clk;

    assign comp0 = (mode == 2'd0) ? (vin >= dac0) : (mode == 2'd1);
    assign comp1 = 1'b1;

    adc_sar_control dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .cont_i(cont),
        .comparator_i(comp0), .sample_o(sample0),
        .comp_strobe_o(strobe0), .dac_code_o(dac0),
        .result_o(result0), .valid_o(valid0), .busy_o(busy0)
    );

    adc_sar_control #(.SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .cont_i(1'b0),
        .comparator_i(comp1), .sample_o(sample1),
        .comp_strobe_o(strobe1), .dac_code_o(dac1),
        .result_o(result1), .valid_o(valid1), .busy_o(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_sample"}, 32'(sample0), 0);
        chk({tag, "_strobe"}, 32'(strobe0), 0);
        chk({tag, "_dac"}, 32'(dac0), 0);
        chk({tag, "_result"}, 32'(result0), 0);
        chk({tag, "_valid"}, 32'(valid0), 0);
        chk({tag, "_busy"}, 32'(busy0), 0);
    endtask

    // Cycle n is the n-th clock period after the edge that sees start.
    task automatic run(input logic [11:0] v1, input logic [11:0] v2,
                       input bit cmode, input int poke, input int ncyc);
        vcyc.delete();
        vres.delete();
        trials.delete();
        vin  = v1;
        cont = cmode;
        @(negedge clk);
        start0 = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            start0 = (n == poke);
            busy_at[n]   = busy0;
            strobe_at[n] = strobe0;
            if (strobe0) trials.push_back(dac0);
            if (vcyc.size() == 1 && n > vcyc[0]) cont = 1'b0;
            if (valid0) begin
                vcyc.push_back(n);
                vres.push_back(result0);
                vin = v2;
            end
        end
        cont = 1'b0;
    endtask

    logic [11:0] exp_trials [12] = '{
        12'h800, 12'hC00, 12'hA00, 12'hB00, 12'hA80, 12'hA40,
        12'hA60, 12'hA50, 12'hA58, 12'hA5C, 12'hA5E, 12'hA5D
    };

    initial begin
        int bad;
        int lat;
        int nstb;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        cont   = 1'b0;
        mode   = 2'd0;
        vin    = 12'h000;
        repeat (3) @(negedge clk);
        outs_zero("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        outs_zero("rst_rel");

        run(12'hA5C, 12'hA5C, 1'b0, 0, 34);
        chk("ideal_nvalid", vcyc.size(), 1);
        if (vcyc.size() > 0) begin
            chk("ideal_lat", vcyc[0], 29);
            chk("ideal_res", vres[0], 12'hA5C);
        end
        chk("ideal_ntrial", trials.size(), 12);
        for (int i = 0; i < 12 && i < trials.size(); i++)
            chk($sformatf("trial%0d", i), trials[i], exp_trials[i]);
        bad = 0;
        for (int n = 1; n <= 32; n++)
            if (strobe_at[n] !== (n >= 6 && n <= 28 && n % 2 == 0)) bad++;
        chk("strobe_pattern", bad, 0);
        chk("ideal_busy29", 32'(busy_at[29]), 1);
        chk("ideal_busy30", 32'(busy_at[30]), 0);
        chk("ideal_hold", result0, 12'hA5C);

        @(negedge clk);
        start0 = 1'b1;
        repeat (10) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        outs_zero("rst_mid");

        run(12'h3C7, 12'h3C7, 1'b0, 12, 40);
        chk("poke_nvalid", vcyc.size(), 1);
        if (vcyc.size() > 0) chk("poke_lat", vcyc[0], 29);
        chk("poke_res", result0, 12'h3C7);
        chk("poke_busy29", 32'(busy_at[29]), 1);
        chk("poke_busy30", 32'(busy_at[30]), 0);
        chk("poke_busy35", 32'(busy_at[35]), 0);

        run(12'h123, 12'hEDC, 1'b1, 0, 66);
        chk("cont_nvalid", vcyc.size(), 2);
        if (vcyc.size() == 2) begin
            chk("cont_gap", vcyc[1] - vcyc[0], 29);
            chk("cont_res0", vres[0], 12'h123);
            chk("cont_res1", vres[1], 12'hEDC);
        end
        bad = 0;
        for (int n = 1; n <= 58; n++) if (busy_at[n] !== 1'b1) bad++;
        chk("cont_busy", bad, 0);
        chk("cont_busy59", 32'(busy_at[59]), 0);

        vin = 12'h777;
        @(negedge clk);
        start0 = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        chk("b5_busy_pre", 32'(busy0), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        outs_zero("rst_b5");
        run(12'h5A3, 12'h5A3, 1'b0, 0, 32);
        chk("b5_nvalid", vcyc.size(), 1);
        if (vcyc.size() > 0) chk("b5_res", vres[0], 12'h5A3);

        mode = 2'd1;
        run(12'h000, 12'h000, 1'b0, 0, 32);
        chk("stuck1_res", result0, 12'hFFF);
        mode = 2'd2;
        run(12'h000, 12'h000, 1'b0, 0, 32);
        chk("stuck0_res", result0, 12'h000);
        chk("stuck0_nvalid", vcyc.size(), 1);

        lat  = -1;
        nstb = 0;
        @(negedge clk);
        start1 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (strobe1) nstb++;
            if (valid1 && lat < 0) lat = n;
        end
        chk("fast_lat", lat, 14);
        chk("fast_res", result1, 12'hFFF);
        chk("fast_nstrobe", nstb, 12);
        chk("fast_busy", 32'(busy1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
